// File: rtl/syn_gpu_pkg.sv
// Shared GPU pixel-path types: pixel format, coordinate widths and line-rasteriser command/state types.
package syn_gpu_pkg;

  localparam int P_X_W        = 8;
  localparam int P_Y_W        = 8;
  localparam int P_LINE_ERR_W = ((P_X_W > P_Y_W) ? P_X_W : P_Y_W) + 2;

  typedef struct packed {
    logic [7:0] h;
    logic [3:0] s;
    logic [3:0] i;
  } pxl_hsi_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } line_fsm_t;

  typedef struct packed {
    logic [P_X_W-1:0] x0;
    logic [P_Y_W-1:0] y0;
    logic [P_X_W-1:0] x1;
    logic [P_Y_W-1:0] y1;
    pxl_hsi_t         colour;
  } line_cmd_t;

endpackage

// File: rtl/syn_gpu_bres_step.sv
// One Bresenham step: next error term and coordinates from the current walk state.
module syn_gpu_bres_step #(
  parameter int E_W    = 10,
  parameter int WIDTHX = 8,
  parameter int WIDTHY = 8
) (
  input  logic signed [E_W-1:0]    err,
  input  logic signed [E_W-1:0]    dx,
  input  logic signed [E_W-1:0]    dy,
  input  logic signed [E_W-1:0]    sx,
  input  logic signed [E_W-1:0]    sy,
  input  logic        [WIDTHX-1:0] x,
  input  logic        [WIDTHY-1:0] y,
  output logic signed [E_W-1:0]    err_nxt,
  output logic        [WIDTHX-1:0] x_nxt,
  output logic        [WIDTHY-1:0] y_nxt
);

  localparam logic signed [E_W-1:0] ZERO = '0;

  logic signed [E_W:0] e2;
  logic                step_x;
  logic                step_y;

  // Both decisions use the pre-update error; one extra bit keeps 2*err exact.
  always_comb begin
    e2      = {err, 1'b0};
    step_x  = (e2 >= (E_W+1)'(dy));
    step_y  = (e2 <= (E_W+1)'(dx));
    err_nxt = err + (step_x ? dy : ZERO) + (step_y ? dx : ZERO);
    x_nxt   = step_x ? WIDTHX'(E_W'(x) + sx) : x;
    y_nxt   = step_y ? WIDTHY'(E_W'(y) + sy) : y;
  end

endmodule

// File: rtl/syn_gpu_line_drawer.sv
// Bresenham line rasteriser: one command in, one pixel write per accepted cycle out.
module syn_gpu_line_drawer
  import syn_gpu_pkg::*;
#(
  parameter type PIXEL_TYPE = pxl_hsi_t,
  parameter int  WIDTHX     = P_X_W,
  parameter int  WIDTHY     = P_Y_W
) (
  input  logic              clk_ir,
  input  logic              rst_il,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTHX-1:0] x0,
  input  logic [WIDTHX-1:0] x1,
  input  logic [WIDTHY-1:0] y0,
  input  logic [WIDTHY-1:0] y1,
  input  PIXEL_TYPE         colour,
  output logic              busy,
  output logic              done,
  output PIXEL_TYPE         pxl,
  output logic              pxl_wr_valid,
  input  logic              pxl_wr_ready,
  output logic [WIDTHX-1:0] posx,
  output logic [WIDTHY-1:0] posy
);

  localparam int E_W = ((WIDTHX > WIDTHY) ? WIDTHX : WIDTHY) + 2;

  function automatic logic signed [E_W-1:0] span(input logic [E_W-1:0] a,
                                                 input logic [E_W-1:0] b);
    logic signed [E_W-1:0] d;
    d = signed'(a - b);
    return (d < 0) ? -d : d;
  endfunction

  function automatic logic signed [E_W-1:0] dir(input logic [E_W-1:0] from,
                                                input logic [E_W-1:0] to);
    return (from < to) ? E_W'(1) : '1;
  endfunction

  line_fsm_t             state;
  logic [WIDTHX-1:0]     cmd_x0;
  logic [WIDTHX-1:0]     cmd_x1;
  logic [WIDTHY-1:0]     cmd_y0;
  logic [WIDTHY-1:0]     cmd_y1;
  PIXEL_TYPE             cmd_colour;
  logic signed [E_W-1:0] dx;
  logic signed [E_W-1:0] dy;
  logic signed [E_W-1:0] sx;
  logic signed [E_W-1:0] sy;
  logic signed [E_W-1:0] err;
  logic signed [E_W-1:0] err_nxt;
  logic [WIDTHX-1:0]     x_nxt;
  logic [WIDTHY-1:0]     y_nxt;
  logic                  accept;
  logic                  at_end;

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign accept = pxl_wr_valid && pxl_wr_ready;
  assign at_end = (posx == cmd_x1) && (posy == cmd_y1);

  syn_gpu_bres_step #(
    .E_W   (E_W),
    .WIDTHX(WIDTHX),
    .WIDTHY(WIDTHY)
  ) u_step (
    .err    (err),
    .dx     (dx),
    .dy     (dy),
    .sx     (sx),
    .sy     (sy),
    .x      (posx),
    .y      (posy),
    .err_nxt(err_nxt),
    .x_nxt  (x_nxt),
    .y_nxt  (y_nxt)
  );

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state        <= IDLE;
      cmd_x0       <= '0;
      cmd_x1       <= '0;
      cmd_y0       <= '0;
      cmd_y1       <= '0;
      cmd_colour   <= '0;
      dx           <= '0;
      dy           <= '0;
      sx           <= '0;
      sy           <= '0;
      err          <= '0;
      posx         <= '0;
      posy         <= '0;
      pxl          <= '0;
      pxl_wr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cmd_x0     <= x0;
            cmd_x1     <= x1;
            cmd_y0     <= y0;
            cmd_y1     <= y1;
            cmd_colour <= colour;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            dx           <= span(E_W'(cmd_x1), E_W'(cmd_x0));
            dy           <= -span(E_W'(cmd_y1), E_W'(cmd_y0));
            err          <= span(E_W'(cmd_x1), E_W'(cmd_x0)) - span(E_W'(cmd_y1), E_W'(cmd_y0));
            sx           <= dir(E_W'(cmd_x0), E_W'(cmd_x1));
            sy           <= dir(E_W'(cmd_y0), E_W'(cmd_y1));
            posx         <= cmd_x0;
            posy         <= cmd_y0;
            pxl          <= cmd_colour;
            pxl_wr_valid <= 1'b1;
            state        <= DRAW;
          end
        end
        DRAW: begin
          // Abort wins over advancement; without an accept everything holds.
          if (abort) begin
            pxl_wr_valid <= 1'b0;
            state        <= IDLE;
          end else if (accept) begin
            if (at_end) begin
              pxl_wr_valid <= 1'b0;
              state        <= DONE;
            end else begin
              err  <= err_nxt;
              posx <= x_nxt;
              posy <= y_nxt;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syn_gpu_line_drawer.sv
// Scoreboard bench for syn_gpu_line_drawer: integer Bresenham reference, random lines and backpressure.
module tb_syn_gpu_line_drawer;
  import syn_gpu_pkg::*;

  typedef struct packed {
    logic [P_X_W-1:0] x;
    logic [P_Y_W-1:0] y;
    pxl_hsi_t         c;
  } exp_t;

  logic             clk_ir = 1'b0;
  logic             rst_il = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [P_X_W-1:0] x0 = '0;
  logic [P_X_W-1:0] x1 = '0;
  logic [P_Y_W-1:0] y0 = '0;
  logic [P_Y_W-1:0] y1 = '0;
  pxl_hsi_t         colour = '0;
  logic             pxl_wr_ready = 1'b1;
  logic             busy;
  logic             done;
  logic             pxl_wr_valid;
  pxl_hsi_t         pxl;
  logic [P_X_W-1:0] posx;
  logic [P_Y_W-1:0] posy;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: 3-cycle stall after 2nd pixel
  exp_t exp_q[$];
  int   cnt_q[$];

  syn_gpu_line_drawer dut (
    .clk_ir      (clk_ir),
    .rst_il      (rst_il),
    .start       (start),
    .abort       (abort),
    .x0          (x0),
    .x1          (x1),
    .y0          (y0),
    .y1          (y1),
    .colour      (colour),
    .busy        (busy),
    .done        (done),
    .pxl         (pxl),
    .pxl_wr_valid(pxl_wr_valid),
    .pxl_wr_ready(pxl_wr_ready),
    .posx        (posx),
    .posy        (posy)
  );

  always #5 clk_ir = ~clk_ir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: textbook integer Bresenham walk, plus the closed-form pixel count.
  task automatic model_line(input line_cmd_t c, input bit expect_done);
    int x, y, xe, ye, ddx, ddy, stx, sty, e, e2, n;
    exp_t item;
    x = c.x0; y = c.y0; xe = c.x1; ye = c.y1;
    ddx = (xe > x) ? xe - x : x - xe;
    ddy = (ye > y) ? y - ye : ye - y;
    stx = (x < xe) ? 1 : -1;
    sty = (y < ye) ? 1 : -1;
    e = ddx + ddy;
    n = 0;
    forever begin
      item.x = 8'(x); item.y = 8'(y); item.c = c.colour;
      exp_q.push_back(item);
      n++;
      if ((x == xe && y == ye) || n > 1000) break;
      e2 = 2 * e;
      if (e2 >= ddy) begin e += ddy; x += stx; end
      if (e2 <= ddx) begin e += ddx; y += sty; end
    end
    if (expect_done) cnt_q.push_back(((ddx > -ddy) ? ddx : -ddy) + 1);
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy) break;
      @(negedge clk_ir);
    end
    chk("line_finishes", busy, 0);
  endtask

  // mode 0: plain line, 1: extra start during DRAW, 2: abort on the 3rd pixel
  task automatic run_line(input line_cmd_t c, input int mode);
    model_line(c, mode != 2);
    @(negedge clk_ir);
    x0 = c.x0; y0 = c.y0; x1 = c.x1; y1 = c.y1; colour = c.colour; start = 1'b1;
    @(negedge clk_ir);
    start = 1'b0;
    x0 = 8'($urandom); y0 = 8'($urandom); x1 = 8'($urandom); y1 = 8'($urandom);
    colour = pxl_hsi_t'($urandom);
    chk("setup_valid_low", pxl_wr_valid, 0);
    chk("setup_busy", busy, 1);
    @(negedge clk_ir);
    chk("first_valid", pxl_wr_valid, 1);
    chk("first_posx", posx, c.x0);
    chk("first_posy", posy, c.y0);
    if (mode == 1) begin
      start = 1'b1;
      @(negedge clk_ir);
      start = 1'b0;
      chk("busy_after_ignored_start", busy, 1);
    end
    if (mode == 2) begin
      @(negedge clk_ir);
      @(negedge clk_ir);
      abort = 1'b1;
      @(negedge clk_ir);
      abort = 1'b0;
      chk("abort_valid_low", pxl_wr_valid, 0);
      chk("abort_busy_low", busy, 0);
      chk("abort_no_done", done, 0);
      repeat (3) @(negedge clk_ir);
      exp_q.delete();
    end else begin
      wait_idle(3000);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted pixel and checks holds and done pulses.
  initial begin
    bit   prev_stall = 0;
    bit   abort_e, start_e;
    int   line_pix = 0, stall_cnt = 0, last_acc = -10;
    exp_t snap, e;
    forever begin
      @(posedge clk_ir);
      cyc++;
      abort_e = abort && busy;
      start_e = start && !busy;
      @(negedge clk_ir);
      if (!rst_il) begin
        prev_stall = 0; line_pix = 0; stall_cnt = 0;
        continue;
      end
      if (start_e) begin line_pix = 0; stall_cnt = 0; end
      if (abort_e) line_pix = 0;
      if (prev_stall && !abort_e) begin
        chk("stall_valid_held", pxl_wr_valid, 1);
        chk("stall_posx_held", posx, snap.x);
        chk("stall_posy_held", posy, snap.y);
        chk("stall_pxl_held", pxl, snap.c);
      end
      if (done) begin
        if (cnt_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: done=1 with no line outstanding (cycle %0d)", cyc);
        end else begin
          chk("line_pixel_count", line_pix, cnt_q.pop_front());
          chk("done_one_cycle_after_last", last_acc, cyc);
        end
        line_pix = 0;
      end
      case (ready_mode)
        0: pxl_wr_ready = 1'b1;
        1: pxl_wr_ready = ($urandom_range(3, 0) != 0);
        default: begin
          if (line_pix == 2 && stall_cnt < 3) begin
            pxl_wr_ready = 1'b0;
            stall_cnt++;
          end else begin
            pxl_wr_ready = 1'b1;
          end
        end
      endcase
      if (pxl_wr_valid && pxl_wr_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pixel: got (%0d,%0d) with none expected", posx, posy);
        end else begin
          e = exp_q.pop_front();
          chk("pixel_x", posx, e.x);
          chk("pixel_y", posy, e.y);
          chk("pixel_colour", pxl, e.c);
        end
        line_pix++;
        last_acc = cyc + 1;
      end
      prev_stall = pxl_wr_valid && !pxl_wr_ready;
      snap.x = posx; snap.y = posy; snap.c = pxl;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    line_cmd_t c;
    repeat (3) @(negedge clk_ir);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", pxl_wr_valid, 0);
    chk("reset_posx", posx, 0);
    chk("reset_posy", posy, 0);
    chk("reset_pxl", pxl, 0);
    rst_il = 1'b1;

    ready_mode = 0;
    c = '{x0: 8'd2, y0: 8'd5, x1: 8'd6, y1: 8'd5, colour: 16'h003F};
    run_line(c, 0);
    c = '{x0: 8'd0, y0: 8'd0, x1: 8'd2, y1: 8'd5, colour: 16'h1234};
    run_line(c, 0);
    c = '{x0: 8'd6, y0: 8'd3, x1: 8'd3, y1: 8'd3, colour: 16'h5A5A};
    run_line(c, 0);
    c = '{x0: 8'd7, y0: 8'd7, x1: 8'd7, y1: 8'd7, colour: 16'hBEEF};
    run_line(c, 0);

    ready_mode = 2;
    c = '{x0: 8'd0, y0: 8'd0, x1: 8'd4, y1: 8'd2, colour: 16'hC0DE};
    run_line(c, 0);

    ready_mode = 1;
    c = '{x0: 8'd0, y0: 8'd0, x1: 8'd2, y1: 8'd5, colour: 16'h0F0F};
    run_line(c, 1);

    ready_mode = 0;
    c = '{x0: 8'd0, y0: 8'd0, x1: 8'd10, y1: 8'd0, colour: 16'hAAAA};
    run_line(c, 2);

    // Reset dropped in the middle of a long line.
    c = '{x0: 8'd0, y0: 8'd0, x1: 8'd100, y1: 8'd50, colour: 16'h7777};
    model_line(c, 1);
    @(negedge clk_ir);
    x0 = c.x0; y0 = c.y0; x1 = c.x1; y1 = c.y1; colour = c.colour; start = 1'b1;
    @(negedge clk_ir);
    start = 1'b0;
    repeat (4) @(negedge clk_ir);
    #2 rst_il = 1'b0;
    #1;
    chk("midreset_valid", pxl_wr_valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_posx", posx, 0);
    chk("midreset_posy", posy, 0);
    chk("midreset_pxl", pxl, 0);
    exp_q.delete();
    cnt_q.delete();
    repeat (2) @(negedge clk_ir);
    rst_il = 1'b1;

    c = '{x0: 8'd1, y0: 8'd1, x1: 8'd9, y1: 8'd4, colour: 16'h1357};
    run_line(c, 0);

    ready_mode = 1;
    c = '{x0: 8'd0, y0: 8'd0, x1: 8'd255, y1: 8'd255, colour: 16'hFFFF};
    run_line(c, 0);
    c = '{x0: 8'd255, y0: 8'd0, x1: 8'd0, y1: 8'd200, colour: 16'h8001};
    run_line(c, 0);
    c = '{x0: 8'd255, y0: 8'd255, x1: 8'd0, y1: 8'd0, colour: 16'h4242};
    run_line(c, 0);

    for (int n = 0; n < 30; n++) begin
      c.x0 = 8'($urandom_range(63, 0));
      c.y0 = 8'($urandom_range(63, 0));
      c.x1 = 8'($urandom_range(63, 0));
      c.y1 = 8'($urandom_range(63, 0));
      c.colour = pxl_hsi_t'($urandom);
      run_line(c, 0);
    end

    repeat (5) @(negedge clk_ir);
    chk("pixels_outstanding", exp_q.size(), 0);
    chk("lines_outstanding", cnt_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
